ni_target_request: RTL

- Target-side request decoder for the NoC. It takes request flits from the target NI's in_buffer and decodes the header and payload flits.
- It drives an AXI master interface on the AW, W and AR channels toward a memory or peripheral.
- It records the requesting SOURCE per AXI ID so the target response packetizer can route B and R packets back.
- It enforces an outstanding-transaction limit in each direction.

---
 rtl/ni_target_request_pkg.sv | 46 ++++
 rtl/ni_id_source_table.sv | 31 +++
 rtl/ni_target_request.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ni_target_request_pkg.sv
// Shared definitions for the target-side NI request decoder: flit bit-field
// positions, command encodings, AXI field widths and the decoder FSM states.
package ni_target_request_pkg;

    localparam int AXIIDWD    = 4;
    localparam int AXILENWD   = 8;
    localparam int AXISIZEWD  = 3;
    localparam int AXIBURSTWD = 2;
    localparam int AXIADDRWD  = 32;
    localparam int AXIDATAWD  = 64;
    localparam int AXISTRBWD  = 8;
    localparam int SRCWD      = 4;

    // Header and data flit field positions (80-bit flit)
    localparam int HDR_BIT  = 79;
    localparam int LAST_BIT = 78;
    localparam int SRC_HI   = 77;
    localparam int SRC_LO   = 74;
    localparam int CMD_HI   = 73;
    localparam int CMD_LO   = 72;
    localparam int ID_HI    = 71;
    localparam int ID_LO    = 68;
    localparam int LEN_HI   = 67;
    localparam int LEN_LO   = 60;
    localparam int SIZE_HI  = 59;
    localparam int SIZE_LO  = 57;
    localparam int BURST_HI = 56;
    localparam int BURST_LO = 55;
    localparam int ADDR_HI  = 54;
    localparam int ADDR_LO  = 23;
    localparam int STRB_HI  = 71;
    localparam int STRB_LO  = 64;
    localparam int DATA_HI  = 63;
    localparam int DATA_LO  = 0;

    localparam logic [1:0] CMD_READ  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        AR_ISSUE,
        AW_ISSUE,
        W_DATA
    } tr_state_e;

endpackage

// File: rtl/ni_id_source_table.sv
// Per-AXI-ID record of the requesting SOURCE node; one write port and one
// asynchronous read port, so a same-cycle lookup sees the previous value.
module ni_id_source_table #(
    parameter int DEPTH = 16,
    parameter int IDW   = 4,
    parameter int SRCW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [IDW-1:0]  wr_id,
    input  logic [SRCW-1:0] wr_src,
    input  logic [IDW-1:0]  rd_id,
    output logic [SRCW-1:0] rd_src
);

    logic [SRCW-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_id] <= wr_src;
        end
    end

    assign rd_src = mem[rd_id];

endmodule

// File: rtl/ni_target_request.sv
// Target-side NoC request decoder: turns header/data flits into AXI AW/W/AR
// traffic, remembers the source per ID and limits outstanding transactions.
module ni_target_request
    import ni_target_request_pkg::*;
#(
    parameter int FLIT_WIDTH          = 80,
    parameter int MAX_SUPPORTED_IDS   = 16,
    parameter int MAX_OUTSTANDING     = 8,
    parameter int LOG_MAX_OUTSTANDING = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] flit,
    input  logic                  valid,
    output logic                  stall,
    output logic [AXIIDWD-1:0]    AWID,
    output logic [AXIADDRWD-1:0]  AWADDR,
    output logic [AXILENWD-1:0]   AWLEN,
    output logic [AXISIZEWD-1:0]  AWSIZE,
    output logic [AXIBURSTWD-1:0] AWBURST,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [AXIDATAWD-1:0]  WDATA,
    output logic [AXISTRBWD-1:0]  WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    output logic [AXIIDWD-1:0]    ARID,
    output logic [AXIADDRWD-1:0]  ARADDR,
    output logic [AXILENWD-1:0]   ARLEN,
    output logic [AXISIZEWD-1:0]  ARSIZE,
    output logic [AXIBURSTWD-1:0] ARBURST,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic                  wr_done,
    input  logic                  rd_done,
    input  logic [AXIIDWD-1:0]    wr_lookup_id,
    input  logic [AXIIDWD-1:0]    rd_lookup_id,
    output logic [SRCWD-1:0]      wr_lookup_src,
    output logic [SRCWD-1:0]      rd_lookup_src,
    output logic                  proto_err
);

    localparam int CNTW = LOG_MAX_OUTSTANDING + 1;
    localparam logic [CNTW-1:0]     CNT_MAX  = CNTW'(MAX_OUTSTANDING);
    localparam logic [CNTW-1:0]     CNT_ONE  = CNTW'(1);
    localparam logic [AXILENWD-1:0] BEAT_ONE = AXILENWD'(1);

    tr_state_e state_q, state_d;

    logic                 run_q;
    logic                 all_loaded_q;
    logic                 err_fill_q;
    logic [SRCWD-1:0]     src_q;
    logic [AXILENWD-1:0]  len_q;
    logic [AXILENWD-1:0]  beat_q;
    logic [CNTW-1:0]      rd_cnt_q;
    logic [CNTW-1:0]      wr_cnt_q;

    logic       is_hdr;
    logic [1:0] cmd;
    logic       ar_fire, aw_fire, w_fire, w_room, last_beat;
    logic       stall_c, take_rd, take_wr, w_load_flit, w_load_fill, hdr_in_burst, err_set;

    assign is_hdr    = flit[HDR_BIT];
    assign cmd       = flit[CMD_HI:CMD_LO];
    assign ar_fire   = ARVALID && ARREADY;
    assign aw_fire   = AWVALID && AWREADY;
    assign w_fire    = WVALID && WREADY;
    assign w_room    = !WVALID || WREADY;
    assign last_beat = (beat_q == len_q);
    assign stall     = stall_c;

    function automatic logic [CNTW-1:0] cnt_next(input logic [CNTW-1:0] c,
                                                 input logic inc, input logic dec);
        logic dec_ok;
        dec_ok = dec && (c != '0);
        if (inc && !dec_ok) return c + CNT_ONE;
        if (dec_ok && !inc) return c - CNT_ONE;
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    // Stall is decided first; consumption and transitions then follow from it.
    always_comb begin
        state_d      = state_q;
        stall_c      = 1'b1;
        take_rd      = 1'b0;
        take_wr      = 1'b0;
        w_load_flit  = 1'b0;
        w_load_fill  = 1'b0;
        hdr_in_burst = 1'b0;
        err_set      = 1'b0;
        case (state_q)
            IDLE:    stall_c = valid && is_hdr &&
                               ((cmd == CMD_READ  && rd_cnt_q == CNT_MAX) ||
                                (cmd == CMD_WRITE && wr_cnt_q == CNT_MAX));
            W_DATA:  stall_c = !w_room || all_loaded_q || err_fill_q || (valid && is_hdr);
            default: stall_c = 1'b1;
        endcase
        if (!run_q) stall_c = 1'b1;
        case (state_q)
            IDLE: begin
                if (valid && !stall_c) begin
                    if (is_hdr && cmd == CMD_READ) begin
                        take_rd = 1'b1;
                        state_d = AR_ISSUE;
                    end else if (is_hdr && cmd == CMD_WRITE) begin
                        take_wr = 1'b1;
                        state_d = AW_ISSUE;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            AR_ISSUE: if (ar_fire) state_d = IDLE;
            AW_ISSUE: if (aw_fire) state_d = W_DATA;
            W_DATA: begin
                w_load_flit  = valid && !stall_c;
                w_load_fill  = err_fill_q && !all_loaded_q && w_room;
                hdr_in_burst = valid && is_hdr && !all_loaded_q && !err_fill_q;
                if ((w_load_flit && (flit[LAST_BIT] != last_beat)) || hdr_in_burst)
                    err_set = 1'b1;
                if (w_fire && WLAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A header arriving mid-burst is left waiting; the burst is completed
    // with zero-strobe beats so the slave still sees a well-formed write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ARID <= '0; ARADDR <= '0; ARLEN <= '0; ARSIZE <= '0; ARBURST <= '0; ARVALID <= 1'b0;
            AWID <= '0; AWADDR <= '0; AWLEN <= '0; AWSIZE <= '0; AWBURST <= '0; AWVALID <= 1'b0;
            WDATA <= '0; WSTRB <= '0; WLAST <= 1'b0; WVALID <= 1'b0;
            src_q <= '0; len_q <= '0; beat_q <= '0;
            all_loaded_q <= 1'b0; err_fill_q <= 1'b0; proto_err <= 1'b0;
        end else begin
            if (take_rd) begin
                ARID    <= flit[ID_HI:ID_LO];
                ARADDR  <= flit[ADDR_HI:ADDR_LO];
                ARLEN   <= flit[LEN_HI:LEN_LO];
                ARSIZE  <= flit[SIZE_HI:SIZE_LO];
                ARBURST <= flit[BURST_HI:BURST_LO];
                ARVALID <= 1'b1;
            end else if (ar_fire) begin
                ARVALID <= 1'b0;
            end
            if (take_wr) begin
                AWID    <= flit[ID_HI:ID_LO];
                AWADDR  <= flit[ADDR_HI:ADDR_LO];
                AWLEN   <= flit[LEN_HI:LEN_LO];
                AWSIZE  <= flit[SIZE_HI:SIZE_LO];
                AWBURST <= flit[BURST_HI:BURST_LO];
                AWVALID <= 1'b1;
                len_q   <= flit[LEN_HI:LEN_LO];
            end else if (aw_fire) begin
                AWVALID <= 1'b0;
            end
            if (take_rd || take_wr) src_q <= flit[SRC_HI:SRC_LO];
            if (aw_fire) begin
                beat_q       <= '0;
                all_loaded_q <= 1'b0;
                err_fill_q   <= 1'b0;
            end
            if (hdr_in_burst) err_fill_q <= 1'b1;
            if (w_load_flit || w_load_fill) begin
                WDATA  <= w_load_flit ? flit[DATA_HI:DATA_LO] : '0;
                WSTRB  <= w_load_flit ? flit[STRB_HI:STRB_LO] : '0;
                WLAST  <= last_beat;
                WVALID <= 1'b1;
                beat_q <= beat_q + BEAT_ONE;
                if (last_beat) all_loaded_q <= 1'b1;
            end else if (w_fire) begin
                WVALID <= 1'b0;
            end
            if (err_set) proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= cnt_next(rd_cnt_q, ar_fire, rd_done);
            wr_cnt_q <= cnt_next(wr_cnt_q, aw_fire, wr_done);
        end
    end

    ni_id_source_table #(.DEPTH(MAX_SUPPORTED_IDS), .IDW(AXIIDWD), .SRCW(SRCWD)) u_rd_table (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (ar_fire),
        .wr_id  (ARID),
        .wr_src (src_q),
        .rd_id  (rd_lookup_id),
        .rd_src (rd_lookup_src)
    );

    ni_id_source_table #(.DEPTH(MAX_SUPPORTED_IDS), .IDW(AXIIDWD), .SRCW(SRCWD)) u_wr_table (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (aw_fire),
        .wr_id  (AWID),
        .wr_src (src_q),
        .rd_id  (wr_lookup_id),
        .rd_src (wr_lookup_src)
    );

endmodule
